// File: rtl/view_compositor_if.sv
// Timing/pixel inputs, window-config port and VGA outputs of view_compositor.
interface view_compositor_if #(
   parameter int N_VIEWS = 3,
   parameter int PIX_W   = 12,
   parameter int HC_W    = 11,
   parameter int VC_W    = 10
);
   logic [HC_W-1:0]          hcount_in;
   logic [VC_W-1:0]          vcount_in;
   logic                     hsync_in;
   logic                     vsync_in;
   logic                     blank_in;
   logic [N_VIEWS*PIX_W-1:0] pixel_in;
   logic                     cfg_we;
   logic [2:0]               cfg_view;
   logic [2:0]               cfg_field;
   logic [HC_W-1:0]          cfg_data;
   logic                     cfg_pending;
   logic [3:0]               vga_r;
   logic [3:0]               vga_g;
   logic [3:0]               vga_b;
   logic                     vga_hs;
   logic                     vga_vs;
   logic [15:0]              frame_count;

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, blank_in, pixel_in,
      output cfg_we, cfg_view, cfg_field, cfg_data,
      input  cfg_pending, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_count
   );

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in, pixel_in,
      input  cfg_we, cfg_view, cfg_field, cfg_data,
      output cfg_pending, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_count
   );
endinterface

// File: rtl/view_compositor.sv
// Aligns N_VIEWS renderer streams to MAX_LAT and picks one pixel per cycle from priority-ordered windows.
// Latency MAX_LAT+1 cycles from hcount_in to the VGA pins; no backpressure, one pixel accepted every cycle.
module view_compositor #(
   parameter int                     N_VIEWS  = 3,
   parameter int                     PIX_W    = 12,
   parameter int                     HC_W     = 11,
   parameter int                     VC_W     = 10,
   parameter int                     MAX_LAT  = 8,
   parameter logic [N_VIEWS*4-1:0]   VIEW_LAT = {4'd4, 4'd1, 4'd4},
   parameter logic [PIX_W-1:0]       BG_COLOR = 12'h000
) (
   input logic              clk_in,
   input logic              rst_in,
   view_compositor_if.slave bus
);

   typedef struct packed {
      logic [HC_W-1:0] hc;
      logic [VC_W-1:0] vc;
      logic            hs;
      logic            vs;
      logic            blank;
   } tm_t;

   typedef struct packed {
      logic [HC_W-1:0] x0;
      logic [HC_W-1:0] x1;
      logic [VC_W-1:0] y0;
      logic [VC_W-1:0] y1;
      logic            en;
   } win_t;

   localparam tm_t TM_RST = '{hc: '0, vc: '0, hs: 1'b0, vs: 1'b0, blank: 1'b1};

   tm_t              tm_sr [MAX_LAT];
   tm_t              al;
   win_t             shadow [N_VIEWS];
   win_t             active [N_VIEWS];
   logic [PIX_W-1:0] pix_al [N_VIEWS];
   logic [PIX_W-1:0] sel;
   logic             vs_prev;
   logic             commit;
   logic             wr_ok;
   logic             pending;
   logic [15:0]      fc;
   logic [11:0]      rgb_q;
   logic             hs_q;
   logic             vs_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int k = 0; k < MAX_LAT; k++) tm_sr[k] <= TM_RST;
      end else begin
         tm_sr[0] <= '{hc: bus.hcount_in, vc: bus.vcount_in, hs: bus.hsync_in,
                       vs: bus.vsync_in, blank: bus.blank_in};
         for (int k = 1; k < MAX_LAT; k++) tm_sr[k] <= tm_sr[k-1];
      end
   end

   assign al = tm_sr[MAX_LAT-1];

   // Slow renderers need fewer stages so every view lands on stage MAX_LAT together.
   for (genvar g = 0; g < N_VIEWS; g++) begin : g_align
      localparam int DEPTH = MAX_LAT - int'(VIEW_LAT[g*4 +: 4]);
      if (DEPTH == 0) begin : g_wire
         assign pix_al[g] = bus.pixel_in[g*PIX_W +: PIX_W];
      end else begin : g_dly
         logic [PIX_W-1:0] sr [DEPTH];
         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
               for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
            end else begin
               sr[0] <= bus.pixel_in[g*PIX_W +: PIX_W];
               for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
            end
         end
         assign pix_al[g] = sr[DEPTH-1];
      end
   end

   assign commit = bus.vsync_in & ~vs_prev;
   assign wr_ok  = bus.cfg_we && (32'(bus.cfg_view) < N_VIEWS) && (bus.cfg_field <= 3'd4);

   // Commit copies the old shadow; a same-cycle write still lands in shadow and keeps pending set.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vs_prev <= 1'b0;
         pending <= 1'b0;
         fc      <= '0;
         for (int i = 0; i < N_VIEWS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         vs_prev <= bus.vsync_in;
         if (commit) begin
            for (int i = 0; i < N_VIEWS; i++) active[i] <= shadow[i];
            fc <= fc + 16'd1;
         end
         for (int i = 0; i < N_VIEWS; i++) begin
            if (wr_ok && 32'(bus.cfg_view) == i) begin
               case (bus.cfg_field)
                  3'd0:    shadow[i].x0 <= bus.cfg_data;
                  3'd1:    shadow[i].y0 <= bus.cfg_data[VC_W-1:0];
                  3'd2:    shadow[i].x1 <= bus.cfg_data;
                  3'd3:    shadow[i].y1 <= bus.cfg_data[VC_W-1:0];
                  3'd4:    shadow[i].en <= bus.cfg_data[0];
                  default: ;
               endcase
            end
         end
         if (wr_ok)       pending <= 1'b1;
         else if (commit) pending <= 1'b0;
      end
   end

   // Walk from highest index down so the lowest-index hit overwrites the rest.
   always_comb begin
      sel = BG_COLOR;
      for (int i = N_VIEWS-1; i >= 0; i--) begin
         if (active[i].en &&
             al.hc >= active[i].x0 && al.hc < active[i].x1 &&
             al.vc >= active[i].y0 && al.vc < active[i].y1)
            sel = pix_al[i];
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else begin
         rgb_q <= al.blank ? 12'h000 : sel[11:0];
         hs_q  <= ~al.hs;
         vs_q  <= ~al.vs;
      end
   end

   assign bus.vga_r       = rgb_q[11:8];
   assign bus.vga_g       = rgb_q[7:4];
   assign bus.vga_b       = rgb_q[3:0];
   assign bus.vga_hs      = hs_q;
   assign bus.vga_vs      = vs_q;
   assign bus.cfg_pending = pending;
   assign bus.frame_count = fc;

endmodule
